// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

    localparam int DEF_RST_HOLD_CYCLES     = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 7;

    localparam logic [2:0] HOLD_ENC   = 3'd0;
    localparam logic [2:0] WAIT_ENC   = 3'd1;
    localparam logic [2:0] STABLE_ENC = 3'd2;
    localparam logic [2:0] RUN_ENC    = 3'd3;
    localparam logic [2:0] FAIL_ENC   = 3'd4;

    typedef enum logic [2:0] {
        S_HOLD      = HOLD_ENC,
        S_WAIT_LOCK = WAIT_ENC,
        S_STABLE    = STABLE_ENC,
        S_RUN       = RUN_ENC,
        S_FAIL      = FAIL_ENC
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer; cleared only by the block reset input.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: HOLD -> WAIT_LOCK -> STABLE -> RUN with retries.
// Define PLL_SEQ_RETRY_LIMIT_EN to enable the FAIL state after MAX_RETRIES.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       out_reset,
    output logic       ready,
    output logic [3:0] retry_count,
    output logic       fail
);

    localparam int MAX_CYC = max3(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                  LOCK_TIMEOUT_CYCLES);
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    retry_nxt;
    logic          lock_s;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        if (relock_req) begin
            state_nxt = S_HOLD;
            if (LIMIT_EN) retry_nxt = '0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == TO_LAST) begin
                        retry_nxt = sat_inc(retry_count);
                        state_nxt = (LIMIT_EN && retry_nxt >= RETRY_LIMIT)
                                  ? S_FAIL : S_HOLD;
                    end
                end
                S_STABLE: begin
                    if (!lock_s)                state_nxt = S_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) state_nxt = S_HOLD;
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_HOLD;
                end
            endcase
        end
        // Counter restarts on every transition and on any relock request
        if (relock_req || state_nxt != state) cnt_nxt = '0;
        else if (&cnt)                        cnt_nxt = cnt;
        else                                  cnt_nxt = cnt + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_HOLD;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            out_reset   <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_rst     <= (state_nxt == S_HOLD) || (state_nxt == S_FAIL);
            out_reset   <= (state_nxt != S_RUN);
            ready       <= (state_nxt == S_RUN);
            fail        <= (state_nxt == S_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with a phase/elapsed-time model.
// Honours PLL_SEQ_RETRY_LIMIT_EN the same way as the design.
module tb_pll_lock_sequencer;

    localparam int RH = 4;
    localparam int LS = 8;
    localparam int TO = 32;
    localparam int MR = 2;

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       out_reset;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;

    typedef struct packed {
        logic       pll_rst;
        logic       out_reset;
        logic       ready;
        logic       fail;
        logic [3:0] retries;
    } exp_t;

    typedef enum int {
        M_RESET_PULSE, M_AWAIT_LOCK, M_QUALIFY, M_RUNNING, M_FAILED
    } mphase_t;

    exp_t    expq[$];
    int      vectors = 0;
    int      miscompares = 0;
    mphase_t phase = M_RESET_PULSE;
    int      elapsed = 0;
    int      retries = 0;
    bit      seen[$] = '{1'b0, 1'b0};

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (RH),
        .LOCK_STABLE_CYCLES  (LS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .MAX_RETRIES         (MR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .out_reset   (out_reset),
        .ready       (ready),
        .retry_count (retry_count),
        .fail        (fail)
    );

    always #5 clock = ~clock;

    function automatic void enter(input mphase_t p);
        phase   = p;
        elapsed = 0;
    endfunction

    // Model of one rising edge; lock is seen two edges after it is driven
    task automatic model_edge(input bit r, input bit lk, input bit rq);
        bit   ls;
        exp_t e;
        ls = seen[0];
        void'(seen.pop_front());
        seen.push_back(lk);
        if (r) begin
            enter(M_RESET_PULSE);
            retries = 0;
            seen = '{1'b0, 1'b0};
        end else if (rq) begin
            enter(M_RESET_PULSE);
            if (LIM) retries = 0;
        end else begin
            elapsed++;
            case (phase)
                M_RESET_PULSE: if (elapsed == RH) enter(M_AWAIT_LOCK);
                M_AWAIT_LOCK: begin
                    if (ls) begin
                        enter(M_QUALIFY);
                    end else if (elapsed == TO) begin
                        retries = (retries < 15) ? retries + 1 : 15;
                        if (LIM && retries >= MR) enter(M_FAILED);
                        else                      enter(M_RESET_PULSE);
                    end
                end
                M_QUALIFY: begin
                    if (!ls)               enter(M_AWAIT_LOCK);
                    else if (elapsed == LS) enter(M_RUNNING);
                end
                M_RUNNING: if (!ls) enter(M_RESET_PULSE);
                default: ;
            endcase
        end
        e.pll_rst   = (phase == M_RESET_PULSE) || (phase == M_FAILED);
        e.out_reset = (phase != M_RUNNING);
        e.ready     = (phase == M_RUNNING);
        e.fail      = (phase == M_FAILED);
        e.retries   = 4'(retries);
        expq.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit lk, input bit rq);
        @(negedge clock);
        reset      = r;
        pll_locked = lk;
        relock_req = rq;
        model_edge(r, lk, rq);
    endtask

    task automatic bound_fail(input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: model phase %0d not reached within bound", what, phase);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                vectors++;
                if ({pll_rst, out_reset, ready, fail, retry_count} !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got rst=%b ores=%b rdy=%b fail=%b rc=%0d, want rst=%b ores=%b rdy=%b fail=%b rc=%0d",
                             $time, pll_rst, out_reset, ready, fail, retry_count,
                             e.pll_rst, e.out_reset, e.ready, e.fail, e.retries);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        int len;
        bit lk;
        repeat (3) cyc(1'b1, 1'b1, 1'b0);
        repeat (40) cyc(1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        repeat (700) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        guard = 0;
        while (!(phase == M_QUALIFY && elapsed == 5) && guard < 200) begin
            cyc(1'b0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 200) bound_fail("stable_glitch_setup");
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        repeat (30) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (30) cyc(1'b0, 1'b1, 1'b0);
        guard = 0;
        while (!(phase == M_AWAIT_LOCK && elapsed == 10) && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 200) bound_fail("wait_lock_setup");
        cyc(1'b1, 1'b0, 1'b0);
        repeat (50) cyc(1'b0, 1'b1, 1'b0);
        for (int seg = 0; seg < 120; seg++) begin
            lk  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 60);
            for (int k = 0; k < len; k++) begin
                cyc(($urandom_range(0, 299) == 0),
                    (k < 3 && $urandom_range(0, 3) == 0) ? !lk : lk,
                    ($urandom_range(0, 99) == 0));
            end
        end
        repeat (3) @(negedge clock);
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
